// File: rtl/sdt_pkg.sv
// Shared types and helpers for the SDT arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sdt_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Index width that never collapses to zero, so a 1-master build still has a 1-bit index.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Fill bit replicated across the read data returned to a master whose transaction was aborted.
  localparam logic RD_ERR_VALUE = 1'b1;

endpackage

// File: rtl/sdt_arbiter_if.sv
// SDT bundle around the arbiter: NUM_MASTERS master ports plus one slave port and status.
// Latency: n/a (wiring only).
// Backpressure: SDT req/ack; a request is held until its one-cycle ack.
// Ports: m_* are per-master vectors packed with master i at slice i; s_* is the shared slave
// port; timeout/grant_valid/grant_idx report arbitration status.
// Modport slave is the arbiter's view (it is the target of the masters); modport master is
// the surrounding environment (masters plus the real SDT target).
interface sdt_arbiter_if #(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8
);
  import sdt_pkg::*;

  localparam int IDX_WIDTH = clog2_min1(NUM_MASTERS);

  logic [NUM_MASTERS-1:0]            m_rd;
  logic [NUM_MASTERS-1:0]            m_wr;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wr_data;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_rd_data;
  logic [NUM_MASTERS-1:0]            m_ack;
  logic                              s_rd;
  logic                              s_wr;
  logic [ADDR_WIDTH-1:0]             s_addr;
  logic [DATA_WIDTH-1:0]             s_wr_data;
  logic [DATA_WIDTH-1:0]             s_rd_data;
  logic                              s_ack;
  logic                              timeout;
  logic                              grant_valid;
  logic [IDX_WIDTH-1:0]              grant_idx;

  modport slave (
    input  m_rd, m_wr, m_addr, m_wr_data, s_rd_data, s_ack,
    output m_rd_data, m_ack, s_rd, s_wr, s_addr, s_wr_data, timeout, grant_valid, grant_idx
  );

  modport master (
    output m_rd, m_wr, m_addr, m_wr_data, s_rd_data, s_ack,
    input  m_rd_data, m_ack, s_rd, s_wr, s_addr, s_wr_data, timeout, grant_valid, grant_idx
  );

endinterface

// File: rtl/sdt_rr_pick.sv
// Round-robin picker: first set request strictly after 'last', wrapping around.
// Latency: purely combinational.
// Backpressure: none; any=0 when nobody requests.
// Ports: req (per-master request), last (previous winner) -> any, idx (winner).
module sdt_rr_pick
  import sdt_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int IDX_WIDTH   = clog2_min1(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_WIDTH-1:0]   last,
  output logic                   any,
  output logic [IDX_WIDTH-1:0]   idx
);

  localparam int PW = $clog2(2 * NUM_MASTERS);

  // Two copies back to back let the search run upward from last+1 without modular indexing.
  logic [2*NUM_MASTERS-1:0] dbl;
  logic [PW-1:0]            pos;
  logic [PW-1:0]            wrapped;
  logic                     found;

  assign dbl = {req, req};

  always_comb begin
    any     = |req;
    idx     = '0;
    found   = 1'b0;
    pos     = '0;
    wrapped = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      pos = PW'(last) + PW'(k);
      if (!found && dbl[pos]) begin
        found   = 1'b1;
        wrapped = (pos >= PW'(NUM_MASTERS)) ? pos - PW'(NUM_MASTERS) : pos;
        idx     = IDX_WIDTH'(wrapped);
      end
    end
  end

endmodule

// File: rtl/sdt_arbiter.sv
// N-to-1 SDT arbiter: round-robin grant, one transaction in flight, optional abort timer.
// Latency: request reaches the slave one cycle after it is raised; ack/data return combinationally.
// Backpressure: losing masters simply hold their request; an IDLE cycle separates transactions.
// Ports: clk, rst (sync, active-high); bus carries the master vectors, slave port and status.
module sdt_arbiter
  import sdt_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int TIMEOUT     = 16
) (
  input  logic         clk,
  input  logic         rst,
  sdt_arbiter_if.slave bus
);

  localparam int IW = clog2_min1(NUM_MASTERS);
  localparam int TW = clog2_min1((TIMEOUT > 1) ? TIMEOUT : 2);
  localparam logic [TW-1:0] T_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  state_e                 state_q, state_d;
  logic [IW-1:0]          last_q;
  logic [IW-1:0]          grant_q;
  logic [TW-1:0]          timer_q;
  logic [NUM_MASTERS-1:0] req;
  logic                   pick_any;
  logic [IW-1:0]          pick_idx;
  logic                   g_req;
  logic                   ack_hit;
  logic                   expire;
  logic                   drop;

  assign req = bus.m_rd | bus.m_wr;

  sdt_rr_pick #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDX_WIDTH   (IW)
  ) u_pick (
    .req  (req),
    .last (last_q),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  // Completion priority: a slave ack always wins (including on the expiry cycle), then a
  // master that abandoned its request, then the timer.
  always_comb begin
    state_d = state_q;
    g_req   = req[grant_q];
    ack_hit = 1'b0;
    expire  = 1'b0;
    drop    = 1'b0;
    if (state_q == BUSY) begin
      if (bus.s_ack) begin
        ack_hit = 1'b1;
      end else if (!g_req) begin
        drop = 1'b1;
      end else if ((TIMEOUT != 0) && (timer_q == T_LAST)) begin
        expire = 1'b1;
      end
      if (ack_hit || drop || expire) begin
        state_d = IDLE;
      end
    end else if (pick_any) begin
      state_d = BUSY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Timer is held at zero while idle so it starts from zero on the first BUSY cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q  <= IW'(NUM_MASTERS - 1);
      grant_q <= '0;
      timer_q <= '0;
    end else if (state_q == IDLE) begin
      timer_q <= '0;
      if (pick_any) begin
        grant_q <= pick_idx;
      end
    end else begin
      timer_q <= timer_q + TW'(1);
      if (ack_hit || drop || expire) begin
        last_q <= grant_q;
      end
    end
  end

  always_comb begin
    bus.s_rd        = 1'b0;
    bus.s_wr        = 1'b0;
    bus.s_addr      = '0;
    bus.s_wr_data   = '0;
    bus.m_ack       = '0;
    bus.m_rd_data   = '0;
    bus.timeout     = expire;
    bus.grant_valid = (state_q == BUSY);
    bus.grant_idx   = grant_q;
    if (state_q == BUSY) begin
      bus.s_rd      = bus.m_rd[grant_q];
      bus.s_wr      = bus.m_wr[grant_q];
      bus.s_addr    = bus.m_addr[grant_q*ADDR_WIDTH +: ADDR_WIDTH];
      bus.s_wr_data = bus.m_wr_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
    end
    if (ack_hit || expire) begin
      bus.m_ack[grant_q] = 1'b1;
      bus.m_rd_data[grant_q*DATA_WIDTH +: DATA_WIDTH] =
        ack_hit ? bus.s_rd_data : {DATA_WIDTH{RD_ERR_VALUE}};
    end
  end

endmodule

// File: tb/tb_sdt_arbiter.sv
`timescale 1ns/1ps
module tb_sdt_arbiter;
  import sdt_pkg::*;

  localparam int NM = 4;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sdt_arbiter_if #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  sdt_arbiter #(
    .NUM_MASTERS (NM),
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .TIMEOUT     (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc++;

  typedef struct packed {
    logic [7:0] data;
    logic       to;
  } exp_t;

  exp_t       expq [NM][$];
  logic [7:0] slv_mem [256];
  logic [7:0] ref_mem [256];
  logic [7:0] log_addr [$];
  int         log_cyc [$];
  int         slv_lat   = -1;
  bit         slv_never = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_s_rd"}, 32'(bus.s_rd), 0);
    check({tag, "_s_wr"}, 32'(bus.s_wr), 0);
    check({tag, "_s_addr"}, 32'(bus.s_addr), 0);
    check({tag, "_s_wr_data"}, 32'(bus.s_wr_data), 0);
    check({tag, "_m_ack"}, 32'(bus.m_ack), 0);
    check({tag, "_m_rd_data"}, 32'(bus.m_rd_data), 0);
    check({tag, "_timeout"}, 32'(bus.timeout), 0);
    check({tag, "_grant_valid"}, 32'(bus.grant_valid), 0);
    check({tag, "_grant_idx"}, 32'(bus.grant_idx), 0);
  endtask

  // SDT master transaction. Called at posedge+1; returns at posedge+1 after the request has
  // been low for one cycle. The expected reply is queued before the request is raised.
  task automatic master_txn(input int i, input bit rd, input logic [7:0] a, input logic [7:0] d,
                            input bit exp_to, output int ack_cyc, output logic [7:0] got);
    exp_t e;
    int   n;
    e.to = exp_to;
    if (exp_to) e.data = 8'hFF;
    else if (rd) e.data = ref_mem[a];
    else begin
      e.data     = 8'h00;
      ref_mem[a] = d;
    end
    expq[i].push_back(e);
    bus.m_addr[i*AW +: AW]    = a;
    bus.m_wr_data[i*DW +: DW] = d;
    bus.m_rd[i] = rd;
    bus.m_wr[i] = !rd;
    ack_cyc = -1;
    got     = 8'h00;
    n       = 0;
    while (ack_cyc < 0 && n < 200) begin
      @(negedge clk);
      if (bus.m_ack[i]) begin
        ack_cyc = cyc;
        got     = bus.m_rd_data[i*DW +: DW];
      end
      n++;
    end
    if (ack_cyc < 0) begin
      checks++;
      errors++;
      $display("FAIL ack_wait master=%0d actual=no_ack required=ack", i);
      void'(expq[i].pop_back());
    end
    @(posedge clk); #1;
    bus.m_rd[i] = 1'b0;
    bus.m_wr[i] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    bus.m_rd = '0;
    bus.m_wr = '0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_cyc.delete();
  endtask

  // SDT target model: acks the (lat+1)th cycle it sees a request, or never when slv_never.
  initial begin : slave_model
    bit active;
    int cnt;
    int lat;
    active = 1'b0;
    cnt    = 0;
    lat    = 0;
    bus.s_ack     = 1'b0;
    bus.s_rd_data = '0;
    forever begin
      @(posedge clk); #2;
      bus.s_ack     = 1'b0;
      bus.s_rd_data = '0;
      if (rst || !(bus.s_rd || bus.s_wr)) begin
        active = 1'b0;
      end else begin
        if (!active) begin
          active = 1'b1;
          cnt    = 0;
          lat    = (slv_lat < 0) ? int'($urandom_range(0, 3)) : slv_lat;
          log_addr.push_back(bus.s_addr);
          log_cyc.push_back(cyc);
        end
        if (!slv_never && cnt == lat) begin
          bus.s_ack = 1'b1;
          if (bus.s_wr) slv_mem[bus.s_addr] = bus.s_wr_data;
          else bus.s_rd_data = slv_mem[bus.s_addr];
          active = 1'b0;
        end else begin
          cnt++;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every ack and checks each new grant against a
  // "next requester after the previous winner" rotation.
  logic [NM-1:0] req_prev   = '0;
  logic          gv_prev    = 1'b0;
  int            last_model = NM - 1;
  exp_t          mon_e;
  int            exp_g;

  always @(negedge clk) begin
    if (rst) begin
      last_model = NM - 1;
      gv_prev    = 1'b0;
    end else begin
      for (int i = 0; i < NM; i++) begin
        if (bus.m_ack[i]) begin
          check("ack_onehot", 32'($countones(bus.m_ack)), 1);
          check("ack_grant_idx", 32'(bus.grant_idx), i);
          for (int j = 0; j < NM; j++)
            if (j != i) check("other_rd_data", 32'(bus.m_rd_data[j*DW +: DW]), 0);
          if (expq[i].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack master=%0d actual=ack required=none", i);
          end else begin
            mon_e = expq[i].pop_front();
            check("ack_data", 32'(bus.m_rd_data[i*DW +: DW]), 32'(mon_e.data));
            check("ack_timeout", 32'(bus.timeout), 32'(mon_e.to));
          end
        end
      end
      if (bus.timeout && bus.m_ack == '0) begin
        checks++;
        errors++;
        $display("FAIL timeout_without_ack actual=1 required=0");
      end
      if (bus.s_rd && bus.s_wr) begin
        checks++;
        errors++;
        $display("FAIL illegal_rd_wr actual=both required=one");
      end
      if (bus.grant_valid && !gv_prev) begin
        exp_g = -1;
        for (int k = 1; k <= NM; k++)
          if (exp_g < 0 && req_prev[(last_model + k) % NM]) exp_g = (last_model + k) % NM;
        if (exp_g < 0) begin
          checks++;
          errors++;
          $display("FAIL grant_without_request actual=%0d required=none", bus.grant_idx);
        end else begin
          check("grant_order", 32'(bus.grant_idx), exp_g);
          check("fwd_addr", 32'(bus.s_addr), 32'(bus.m_addr[exp_g*AW +: AW]));
          check("fwd_rw", 32'({bus.s_rd, bus.s_wr}), 32'({bus.m_rd[exp_g], bus.m_wr[exp_g]}));
          last_model = exp_g;
        end
      end
      gv_prev = bus.grant_valid;
    end
    req_prev = bus.m_rd | bus.m_wr;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "simulation did not finish");
  end

  initial begin : main
    int         ac;
    int         c0;
    int         n;
    logic [7:0] got;

    for (int a = 0; a < 256; a++) begin
      slv_mem[a] = 8'(a * 13 + 7);
      ref_mem[a] = 8'(a * 13 + 7);
    end
    bus.m_rd = '0;
    bus.m_wr = '0;
    bus.m_addr = '0;
    bus.m_wr_data = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Single read from master 2, slave answers 2 cycles after it sees the request.
    slv_mem[8'h3C] = 8'hA5;
    ref_mem[8'h3C] = 8'hA5;
    slv_lat = 2;
    clear_log();
    c0 = cyc;
    master_txn(2, 1'b1, 8'h3C, 8'h00, 1'b0, ac, got);
    check("single_rd_data", 32'(got), 32'hA5);
    if (log_cyc.size() >= 1) begin
      check("single_s_rd_rise", log_cyc[0], c0 + 1);
      check("single_ack_latency", ac - log_cyc[0], 2);
    end else begin
      checks++; errors++;
      $display("FAIL single_slave_seen actual=0 required=1");
    end

    // Round robin: all masters write continuously to a zero-wait slave.
    do_reset();
    slv_lat = 0;
    clear_log();
    for (int i = 0; i < NM; i++) begin
      automatic int mi = i;
      fork
        begin
          int         a2;
          logic [7:0] g2;
          repeat (2) master_txn(mi, 1'b0, 8'(16 + mi), 8'(mi), 1'b0, a2, g2);
        end
      join_none
    end
    wait fork;
    check("rr_count", log_addr.size(), 2 * NM);
    if (log_addr.size() >= 5) begin
      for (int k = 0; k < 5; k++) check("rr_addr", 32'(log_addr[k]), 16 + (k % NM));
      for (int k = 1; k < 5; k++) check("rr_gap", log_cyc[k] - log_cyc[k-1], 2);
    end

    // Masters 3 and 0 request while master 1 is being served: 3 wins, then 0.
    do_reset();
    slv_lat = 3;
    clear_log();
    fork
      begin
        int a1; logic [7:0] g1;
        master_txn(1, 1'b0, 8'h21, 8'hB1, 1'b0, a1, g1);
      end
      begin
        @(posedge clk);
        @(posedge clk); #1;
        fork
          begin int a3; logic [7:0] g3; master_txn(3, 1'b0, 8'h23, 8'hB3, 1'b0, a3, g3); end
          begin int a0; logic [7:0] g0; master_txn(0, 1'b0, 8'h20, 8'hB0, 1'b0, a0, g0); end
        join
      end
    join
    check("simul_count", log_addr.size(), 3);
    if (log_addr.size() >= 3) begin
      check("simul_first", 32'(log_addr[0]), 32'h21);
      check("simul_second", 32'(log_addr[1]), 32'h23);
      check("simul_third", 32'(log_addr[2]), 32'h20);
    end

    // Timeout: slave never acks a write from master 0.
    do_reset();
    slv_never = 1'b1;
    clear_log();
    fork
      master_txn(0, 1'b0, 8'h55, 8'h77, 1'b1, ac, got);
      begin
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!bus.timeout && n < 100);
        if (!bus.timeout) begin
          checks++; errors++;
          $display("FAIL timeout_pulse actual=0 required=1");
        end else begin
          @(negedge clk);
          check("timeout_next_s_wr", 32'(bus.s_wr), 0);
          check("timeout_next_idle", 32'(bus.grant_valid), 0);
        end
      end
    join
    check("timeout_rd_data", 32'(got), 32'hFF);
    if (log_cyc.size() >= 1) check("timeout_cycle", ac - log_cyc[0], TO - 1);
    slv_never = 1'b0;

    // Slave ack lands exactly on the expiry cycle: a normal ack, no timeout.
    do_reset();
    slv_lat = TO - 1;
    clear_log();
    master_txn(0, 1'b1, 8'h40, 8'h00, 1'b0, ac, got);
    check("expiry_ack_data", 32'(got), 32'(8'(8'h40 * 13 + 7)));
    if (log_cyc.size() >= 1) check("expiry_ack_cycle", ac - log_cyc[0], TO - 1);

    // Reset while master 1 is in flight, then a 0/1 tie resolves to master 0.
    do_reset();
    slv_never = 1'b1;
    bus.m_addr[1*AW +: AW] = 8'h31;
    bus.m_rd[1] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("midop_busy", 32'(bus.grant_valid), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_outputs_zero("midop_reset");
    @(posedge clk); #1;
    bus.m_rd[1] = 1'b0;
    rst = 1'b0;
    slv_never = 1'b0;
    slv_lat = 0;
    clear_log();
    fork
      begin int a0; logic [7:0] g0; master_txn(0, 1'b1, 8'h30, 8'h00, 1'b0, a0, g0); end
      begin int a1; logic [7:0] g1; master_txn(1, 1'b1, 8'h31, 8'h00, 1'b0, a1, g1); end
    join
    if (log_addr.size() >= 2) begin
      check("post_reset_first", 32'(log_addr[0]), 32'h30);
      check("post_reset_second", 32'(log_addr[1]), 32'h31);
    end else begin
      checks++; errors++;
      $display("FAIL post_reset_count actual=%0d required=2", log_addr.size());
    end

    // Random traffic; each master owns addresses whose low bits equal its index.
    do_reset();
    slv_lat = -1;
    for (int i = 0; i < NM; i++) begin
      automatic int mi = i;
      fork
        begin
          int         ar;
          logic [7:0] gr;
          logic [7:0] ad;
          repeat (15) begin
            repeat ($urandom_range(0, 3)) begin
              @(posedge clk); #1;
            end
            ad = {6'($urandom), 2'(mi)};
            master_txn(mi, 1'($urandom), ad, 8'($urandom), 1'b0, ar, gr);
          end
        end
      join_none
    end
    wait fork;

    repeat (3) @(posedge clk);
    for (int i = 0; i < NM; i++) check("queue_drain", expq[i].size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
